dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory behind the DMem controller between the processor's I/O controller (port 0) and a second bus master (port 1: program loader or DMA engine). It serializes word accesses, using round-robin on ties and a bounded burst tenure so neither master starves. It forwards the granted request to the memory controller's write-enable, index and data inputs, and returns a registered read-valid to the owner.

## Interface
- DBITS, 32, data word width
- DMEMINDEXBITS, 11, word-index width (2048 words)
- BURST_MAX, 4, max consecutive granted cycles for one owner while the other port waits; legal range 1..256

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0, req1  in  1 each  request; held with address, write flag and data until a granted cycle consumes it
- we0, we1  in  1 each  1 = write, 0 = read
- index0, index1  in  DMEMINDEXBITS each  word index
- wdata0, wdata1  in  DBITS each  write data
- gnt0, gnt1  out  1 each  registered grant; the port owns memory this cycle; never both high
- rvalid0, rvalid1  out  1 each  read data valid on rdata this cycle
- rdata  out  DBITS  shared read-data bus, mem_rdata passed through
- mem_we  out  1  write enable to DMem controller
- mem_index  out  DMEMINDEXBITS  word index to DMem controller
- mem_wdata  out  DBITS  write data to DMem controller
- mem_rdata  in  DBITS  DMem read data, valid one cycle after the address is presented

## Operation
- State: owner FSM S ∈ {IDLE, OWN0, OWN1}, tenure counter cnt (width clog2(BURST_MAX), minimum 1), last-owner bit `last`.
- gnt0 = (S==OWN0), gnt1 = (S==OWN1), both decoded directly from the state register.
- Access: portx transacts in a cycle iff gntx && reqx. mem_we = access && wex; mem_index/mem_wdata come from the owning port while it is accessing, and are 0 otherwise.
- A granted cycle with reqx low is a dead cycle: no memory access, no rvalid.
- Next state from IDLE:
  - both req → OWN(!last);
  - req0 only → OWN0;
  - req1 only → OWN1;
  - neither → IDLE.
- Next state from OWNx (y = other port):
  - !reqx → OWNy if reqy, else IDLE;
  - reqx && reqy && cnt==BURST_MAX-1 → OWNy;
  - otherwise stay OWNx.
- Counter and `last`:
  - on every entry into OWNx, cnt←0 and last←x;
  - while staying in OWNx, cnt←min(cnt+1, BURST_MAX-1).
- BURST_MAX=1 gives strict one-cycle alternation under continuous contention.
- An uncontended owner holds the grant indefinitely. The counter saturates and does not wrap.

## Timing
- Reset values: S=IDLE, cnt=0, last=1 (port 0 wins the first tie), gnt0=gnt1=0, rvalid0=rvalid1=0, mem_we=0, mem_index=0, mem_wdata=0.
- Request-to-grant latency:
  - req first sampled high at edge t → gnt high from cycle t+1, if S was IDLE or the other port released;
  - worst case under contention: BURST_MAX+1 cycles.
- Read latency: a read access in cycle c → rvalidx=1 in cycle c+1 with rdata=mem_rdata. rvalid is registered and lasts exactly one cycle per access.
- Back-to-back: an owner holding req gets one access per cycle, so reads stream with rvalid every cycle, one cycle behind.
- Release cost: a requester that drops req after its last gnt cycle leaves one dead owned cycle before the grant moves. This is by design.
- Simultaneous first requests from IDLE resolve by `last`. A switch on burst expiry takes effect on the next edge, with no idle gap.
- Async reset mid-burst: grants drop immediately, and a pending rvalid is discarded (not asserted after reset). Requesters reissue.

## Test plan
- Reset → all outputs 0. Then req0 with a read of index 5 (memory holds 0xDEADBEEF) → gnt0 next cycle, mem_index=5, mem_we=0, rvalid0=1 with rdata=0xDEADBEEF one cycle later.
- req0 and req1 rise together from IDLE, both held, BURST_MAX=4 → grants follow 0,0,0,0,1,1,1,1,0…; gnt0 and gnt1 are never both high.
- BURST_MAX=1, both held → gnt alternates 0,1,0,1 every cycle; writes land in order (verify with memory model).
- req1 alone held for 10 cycles, writing 0x11..0x1A to indices 0..9 → gnt1 continuous, 10 writes, no drop at the saturated counter. req1 falls → one dead cycle, then IDLE.
- Port 0 reads index 3 while port 1 waits; req0 dropped after one access → grant sequence OWN0 (access), OWN0 (dead), OWN1. rvalid0 fires once.
- Reset asserted one cycle after a granted read → rvalid0 stays 0, gnt drops asynchronously. After release, state is IDLE and last=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of the single-ported DMem controller
//
// Purpose:
//    Serializes word accesses from two bus masters onto one data memory.
//    Port 0 is the processor I/O controller and port 1 is the loader/DMA
//    master. Ties from idle go to the port that did not own memory last.
//    A contended owner keeps memory for at most BURST_MAX consecutive
//    cycles. An uncontended owner keeps it indefinitely.
//
// Parameters:
//    DBITS          data word width
//    DMEMINDEXBITS  word-index width
//    BURST_MAX      max consecutive owned cycles while the other port waits (1..256)
//
// Ports:
//    clk                    system clock, rising edge
//    reset                  asynchronous active-high reset
//    req0/req1              request, held with we/index/wdata until consumed
//    we0/we1                1 = write, 0 = read
//    index0/index1          word index
//    wdata0/wdata1          write data
//    gnt0/gnt1              grant, decoded from the owner state register
//    rvalid0/rvalid1        read data valid on rdata this cycle
//    rdata                  shared read-data bus (mem_rdata passed through)
//    mem_we                 write enable to DMem controller
//    mem_index              word index to DMem controller
//    mem_wdata              write data to DMem controller
//    mem_rdata              DMem read data, one cycle after the address

module dmem_arbiter #(
   parameter int DBITS         = 32,
   parameter int DMEMINDEXBITS = 11,
   parameter int BURST_MAX     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0,
   input  logic                     req1,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [DMEMINDEXBITS-1:0] index0,
   input  logic [DMEMINDEXBITS-1:0] index1,
   input  logic [DBITS-1:0]         wdata0,
   input  logic [DBITS-1:0]         wdata1,
   output logic                     gnt0,
   output logic                     gnt1,
   output logic                     rvalid0,
   output logic                     rvalid1,
   output logic [DBITS-1:0]         rdata,
   output logic                     mem_we,
   output logic [DMEMINDEXBITS-1:0] mem_index,
   output logic [DBITS-1:0]         mem_wdata,
   input  logic [DBITS-1:0]         mem_rdata
);

   localparam int CNTW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BURST_MAX - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OWN0 = 2'd1;
   localparam logic [1:0] S_OWN1 = 2'd2;

   logic [1:0]      r_state;
   logic [CNTW-1:0] r_cnt;
   logic            r_last;     // 1: port 1 owned last, so port 0 wins the next tie
   logic            r_rvalid0;
   logic            r_rvalid1;

   logic [1:0]      w_next_state;
   logic            w_acc0;
   logic            w_acc1;
   logic            w_burst_done;
   logic            w_enter_own;
   logic            w_stay_own;

   assign gnt0 = (r_state == S_OWN0);
   assign gnt1 = (r_state == S_OWN1);

   // A granted cycle with the request low is a dead cycle: no access at all.
   assign w_acc0 = gnt0 && req0;
   assign w_acc1 = gnt1 && req1;

   assign mem_we    = (w_acc0 && we0) || (w_acc1 && we1);
   assign mem_index = w_acc0 ? index0 : (w_acc1 ? index1 : '0);
   assign mem_wdata = w_acc0 ? wdata0 : (w_acc1 ? wdata1 : '0);

   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign rdata   = mem_rdata;

   // Tenure is only enforced when the other port is actually waiting.
   assign w_burst_done = (r_cnt == CNT_MAX);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (req0 && req1)
               w_next_state = r_last ? S_OWN0 : S_OWN1;
            else if (req0)
               w_next_state = S_OWN0;
            else if (req1)
               w_next_state = S_OWN1;
            else
               w_next_state = S_IDLE;
         end
         S_OWN0: begin
            if (!req0)
               w_next_state = req1 ? S_OWN1 : S_IDLE;
            else if (req1 && w_burst_done)
               w_next_state = S_OWN1;
            else
               w_next_state = S_OWN0;
         end
         S_OWN1: begin
            if (!req1)
               w_next_state = req0 ? S_OWN0 : S_IDLE;
            else if (req0 && w_burst_done)
               w_next_state = S_OWN0;
            else
               w_next_state = S_OWN1;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_enter_own = (w_next_state != r_state) && (w_next_state != S_IDLE);
   assign w_stay_own  = (w_next_state == r_state) && (r_state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last    <= 1'b1;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         // Memory returns read data one cycle after the address, so the
         // valid flag is simply the read access delayed by one edge.
         r_rvalid0 <= w_acc0 && !we0;
         r_rvalid1 <= w_acc1 && !we1;
         if (w_enter_own) begin
            r_cnt  <= '0;
            r_last <= (w_next_state == S_OWN1);
         end else if (w_stay_own && !w_burst_done) begin
            // Saturate rather than wrap so a long solo tenure never
            // looks like a fresh one.
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
